sr_fifo_arb: RTL and testbench

Shares the single sr_fifo instance between two requesters: the CPU core (fifoPush/fifoPop from sr_control) and an external host port.
- Separate push and pop channels, each with its own two-way round-robin arbitration.
- Owns the occupancy count and guards against full and empty.
- Stalls the CPU when its FIFO op is not granted.
- Provides a host-initiated flush sequence.
- Sits between sr_cpu and sr_fifo; sr_fifo's enables and write data are driven only by this block.

---
 rtl/sr_fifo_arb_pkg.sv | 14 +
 rtl/sr_rr_arb2.sv | 46 ++++
 rtl/sr_fifo_arb.sv | 112 +++++++++++
 tb/tb_sr_fifo_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_fifo_arb_pkg.sv
// rtl/sr_fifo_arb_pkg.sv - shared state and requester encodings for sr_fifo_arb
package sr_fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_e;

endpackage

// File: rtl/sr_rr_arb2.sv
// rtl/sr_rr_arb2.sv - two-requester round-robin arbiter (CPU vs host)
// Option: SR_FIFO_ARB_CPU_PRIO_EN gives the CPU fixed priority and drops the last-grant register.
module sr_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic cpu_req_i,
  input  logic host_req_i,
  output logic cpu_gnt_o,
  output logic host_gnt_o
);
  import sr_fifo_arb_pkg::*;

`ifdef SR_FIFO_ARB_CPU_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign cpu_gnt_o  = en_i & cpu_req_i;
  assign host_gnt_o = en_i & host_req_i & ~cpu_req_i;
`else
  req_e last_q, last_d;

  always_comb begin
    cpu_gnt_o  = 1'b0;
    host_gnt_o = 1'b0;
    last_d     = last_q;
    if (en_i) begin
      if (cpu_req_i && host_req_i) begin
        // On contention the requester that did not win last time goes first.
        if (last_q == REQ_HOST) cpu_gnt_o  = 1'b1;
        else                    host_gnt_o = 1'b1;
      end else begin
        cpu_gnt_o  = cpu_req_i;
        host_gnt_o = host_req_i;
      end
    end
    if (cpu_gnt_o)       last_d = REQ_CPU;
    else if (host_gnt_o) last_d = REQ_HOST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_HOST;
    else        last_q <= last_d;
  end
`endif

endmodule

// File: rtl/sr_fifo_arb.sv
// rtl/sr_fifo_arb.sv - CPU/host arbitration, occupancy tracking and flush for the shared sr_fifo
// Option: SR_FIFO_ARB_CPU_PRIO_EN (passed through to sr_rr_arb2).
module sr_fifo_arb #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpuPush,
  input  logic                       cpuPop,
  input  logic [FIFO_DATA_WIDTH-1:0] cpuWData,
  output logic [FIFO_DATA_WIDTH-1:0] cpuRData,
  output logic                       cpuStall,
  input  logic                       hostPushValid,
  input  logic [FIFO_DATA_WIDTH-1:0] hostPushData,
  output logic                       hostPushReady,
  input  logic                       hostPopReq,
  output logic                       hostPopValid,
  output logic [FIFO_DATA_WIDTH-1:0] hostPopData,
  input  logic                       hostFlush,
  output logic                       flushDone,
  output logic                       fifoPush,
  output logic [FIFO_DATA_WIDTH-1:0] fifoWData,
  output logic                       fifoPop,
  input  logic [FIFO_DATA_WIDTH-1:0] fifoRData,
  output logic [CNT_W-1:0]           fifoCount
);
  import sr_fifo_arb_pkg::*;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  state_e                     state_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       host_pop_valid_q;
  logic [FIFO_DATA_WIDTH-1:0] host_pop_data_q;
  logic                       flush_done_q;

  logic idle, push_en, pop_en;
  logic cpu_push_gnt, host_push_gnt, cpu_pop_gnt, host_pop_gnt;
  logic flush_drain;

  assign idle    = (state_q == ST_IDLE);
  // No bypass: eligibility looks only at the registered count.
  assign push_en = idle && (count_q < FULL_CNT);
  assign pop_en  = idle && (count_q != '0);

  sr_rr_arb2 u_push_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (push_en),
    .cpu_req_i  (cpuPush),
    .host_req_i (hostPushValid),
    .cpu_gnt_o  (cpu_push_gnt),
    .host_gnt_o (host_push_gnt)
  );

  sr_rr_arb2 u_pop_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (pop_en),
    .cpu_req_i  (cpuPop),
    .host_req_i (hostPopReq),
    .cpu_gnt_o  (cpu_pop_gnt),
    .host_gnt_o (host_pop_gnt)
  );

  assign flush_drain   = (state_q == ST_FLUSH) && (count_q != '0);
  assign fifoPush      = cpu_push_gnt | host_push_gnt;
  assign fifoWData     = cpu_push_gnt ? cpuWData : hostPushData;
  assign fifoPop       = cpu_pop_gnt | host_pop_gnt | flush_drain;
  assign count_d       = count_q + CNT_W'(fifoPush) - CNT_W'(fifoPop);
  assign fifoCount     = count_q;

  assign cpuStall      = (cpuPush & ~cpu_push_gnt) | (cpuPop & ~cpu_pop_gnt);
  assign cpuRData      = fifoRData;
  assign hostPushReady = host_push_gnt;
  assign hostPopValid  = host_pop_valid_q;
  assign hostPopData   = host_pop_data_q;
  assign flushDone     = flush_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      count_q          <= '0;
      host_pop_valid_q <= 1'b0;
      host_pop_data_q  <= '0;
      flush_done_q     <= 1'b0;
    end else begin
      count_q          <= count_d;
      host_pop_valid_q <= host_pop_gnt;
      flush_done_q     <= 1'b0;
      if (host_pop_gnt) host_pop_data_q <= fifoRData;
      case (state_q)
        ST_IDLE: if (hostFlush) state_q <= ST_FLUSH;
        ST_FLUSH: begin
          if (count_q == '0) begin
            state_q      <= ST_IDLE;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifoPush && !fifoPop && count_q == FULL_CNT));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifoPop && count_q == '0));

endmodule

// File: tb/tb_sr_fifo_arb.sv
// tb/tb_sr_fifo_arb.sv - scoreboard bench for sr_fifo_arb with a behavioural sr_fifo
module tb_sr_fifo_arb;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpuPush = 1'b0, cpuPop = 1'b0;
  logic [DW-1:0] cpuWData = '0, cpuRData;
  logic          cpuStall;
  logic          hostPushValid = 1'b0;
  logic [DW-1:0] hostPushData = '0;
  logic          hostPushReady;
  logic          hostPopReq = 1'b0;
  logic          hostPopValid;
  logic [DW-1:0] hostPopData;
  logic          hostFlush = 1'b0;
  logic          flushDone;
  logic          fifoPush, fifoPop;
  logic [DW-1:0] fifoWData;
  logic [DW-1:0] fifoRData = '0;
  logic [CW-1:0] fifoCount;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_q[$];

  always #5 clk = ~clk;

  sr_fifo_arb #(.FIFO_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuPush(cpuPush), .cpuPop(cpuPop), .cpuWData(cpuWData), .cpuRData(cpuRData),
    .cpuStall(cpuStall),
    .hostPushValid(hostPushValid), .hostPushData(hostPushData), .hostPushReady(hostPushReady),
    .hostPopReq(hostPopReq), .hostPopValid(hostPopValid), .hostPopData(hostPopData),
    .hostFlush(hostFlush), .flushDone(flushDone),
    .fifoPush(fifoPush), .fifoWData(fifoWData), .fifoPop(fifoPop), .fifoRData(fifoRData),
    .fifoCount(fifoCount)
  );

  // Behavioural sr_fifo: combinational head, shares rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q.delete();
      fifoRData <= '0;
    end else begin
      if (fifoPop && mem_q.size() != 0) void'(mem_q.pop_front());
      if (fifoPush) mem_q.push_back(fifoWData);
      fifoRData <= (mem_q.size() != 0) ? mem_q[0] : '0;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] sb_pop();
    if (exp_q.size() == 0) return 'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  task automatic host_push(input logic [DW-1:0] d);
    hostPushValid = 1'b1;
    hostPushData  = d;
    #1 check("host_push_ready", hostPushReady, 1);
    exp_q.push_back(d);
    step();
    hostPushValid = 1'b0;
  endtask

  task automatic host_pop_one();
    hostPopReq = 1'b1;
    #1 check("host_pop_fifopop", fifoPop, 1);
    step();
    hostPopReq = 1'b0;
    check("host_pop_valid", hostPopValid, 1);
    check("host_pop_data", hostPopData, sb_pop());
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_count", fifoCount, 0);
    check("rst_pop_valid", hostPopValid, 0);
    check("rst_pop_data", hostPopData, 0);
    check("rst_flush_done", flushDone, 0);
    check("rst_stall", cpuStall, 0);
    rst_n = 1'b1;
    step();

    // Push contention: CPU first, then host, then CPU again (round robin)
    cpuPush = 1'b1; cpuWData = 'h11; hostPushValid = 1'b1; hostPushData = 'h22;
    #1 check("rr1_stall", cpuStall, 0);
    check("rr1_host_ready", hostPushReady, 0);
    check("rr1_wdata", fifoWData, 'h11);
    exp_q.push_back('h11);
    step();
    cpuPush = 1'b0;
    check("rr1_count", fifoCount, 1);
    #1 check("rr2_host_ready", hostPushReady, 1);
    exp_q.push_back('h22);
    step();
    check("rr2_count", fifoCount, 2);
    cpuPush = 1'b1; cpuWData = 'h12; hostPushData = 'h23;
    #1 check("rr3_stall", cpuStall, 0);
    check("rr3_host_ready", hostPushReady, 0);
    exp_q.push_back('h12);
    step();
    cpuPush = 1'b0; hostPushValid = 1'b0;
    while (exp_q.size() != 0) host_pop_one();
    step();
    check("rr_drain_valid", hostPopValid, 0);
    check("rr_drain_count", fifoCount, 0);

    // Full FIFO blocks CPU push until the cycle after a host pop
    for (int i = 0; i < DEPTH; i++) host_push('h100 + i);
    check("full_count", fifoCount, DEPTH);
    cpuPush = 1'b1; cpuWData = 'hAA;
    #1 check("full_stall", cpuStall, 1);
    check("full_no_push", fifoPush, 0);
    step();
    hostPopReq = 1'b1;
    #1 check("full_pop_stall", cpuStall, 1);
    check("full_pop_no_push", fifoPush, 0);
    step();
    hostPopReq = 1'b0;
    check("full_pop_valid", hostPopValid, 1);
    check("full_pop_data", hostPopData, sb_pop());
    #1 check("full_after_stall", cpuStall, 0);
    exp_q.push_back('hAA);
    step();
    cpuPush = 1'b0;
    check("full_refill_count", fifoCount, DEPTH);
    while (exp_q.size() != 0) host_pop_one();

    // Empty FIFO: pop blocked, push proceeds, pop granted next cycle
    step();
    cpuPop = 1'b1; hostPushValid = 1'b1; hostPushData = 'h33;
    #1 check("empty_pop_stall", cpuStall, 1);
    check("empty_push_ready", hostPushReady, 1);
    exp_q.push_back('h33);
    step();
    hostPushValid = 1'b0;
    #1 check("empty_pop_nostall", cpuStall, 0);
    check("empty_cpu_rdata", cpuRData, sb_pop());
    step();
    cpuPop = 1'b0;
    check("empty_count", fifoCount, 0);

    // Host pop with three entries
    for (int i = 0; i < 3; i++) host_push('h41 + i);
    host_pop_one();
    check("pop3_count", fifoCount, 2);

    // Flush five entries with every requester active
    for (int i = 0; i < 3; i++) host_push('h50 + i);
    check("flush_pre_count", fifoCount, 5);
    hostFlush = 1'b1;
    step();
    hostFlush = 1'b0;
    cpuPush = 1'b1; cpuPop = 1'b1; hostPushValid = 1'b1; hostPopReq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 check("flush_pop", fifoPop, 1);
      check("flush_stall", cpuStall, 1);
      check("flush_host_ready", hostPushReady, 0);
      check("flush_no_push", fifoPush, 0);
      check("flush_done_early", flushDone, 0);
      step();
    end
    check("flush_pop_valid", hostPopValid, 0);
    check("flush_end_count", fifoCount, 0);
    #1 check("flush_end_nopop", fifoPop, 0);
    step();
    cpuPush = 1'b0; cpuPop = 1'b0; hostPushValid = 1'b0; hostPopReq = 1'b0;
    check("flush_done", flushDone, 1);
    exp_q.delete();
    step();
    check("flush_done_pulse", flushDone, 0);

    // Flush of an empty FIFO
    hostFlush = 1'b1;
    step();
    hostFlush = 1'b0;
    #1 check("eflush_nopop", fifoPop, 0);
    check("eflush_wait", flushDone, 0);
    step();
    check("eflush_done", flushDone, 1);
    step();
    check("eflush_pulse", flushDone, 0);

    // Reset during the third flush cycle
    for (int i = 0; i < 5; i++) host_push('h60 + i);
    hostFlush = 1'b1;
    step();
    hostFlush = 1'b0;
    step();
    step();
    check("rflush_mid_count", fifoCount, 3);
    rst_n = 1'b0;
    #1 check("rflush_count", fifoCount, 0);
    check("rflush_nopop", fifoPop, 0);
    check("rflush_done", flushDone, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rflush_no_done", flushDone, 0);
    end
    host_push('h77);
    host_pop_one();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
